// File: rtl/cordic_angle_feeder.sv
// cordic_angle_feeder
//   Accepts an angle in whole degrees, folds it into [-90,90] and converts it
//   to CORDIC units of 0.9 degree (100 = 90 deg). The angle is held stable
//   for LATENCY cycles, then the sine returned by the CORDIC is captured.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high
//   deg_in     : requested angle, signed whole degrees
//   deg_valid  : deg_in valid
//   deg_ready  : block can accept a request
//   xin, yin   : constant CORDIC seeds (XIN_INIT, 0)
//   angle      : CORDIC angle, signed, 0.9 degree units
//   sine_in    : sine returned by the CORDIC
//   sine_out   : captured sine
//   sine_valid : one-cycle pulse when sine_out is updated
//   range_err  : one-cycle pulse when a request outside [-180,180] is rejected
module cordic_angle_feeder #(
  parameter int unsigned       LATENCY  = 8,
  parameter logic signed [7:0] XIN_INIT = 8'sd39
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [8:0] deg_in,
  input  logic              deg_valid,
  output logic              deg_ready,
  output logic signed [7:0] xin,
  output logic signed [7:0] yin,
  output logic signed [7:0] angle,
  input  logic signed [7:0] sine_in,
  output logic signed [7:0] sine_out,
  output logic              sine_valid,
  output logic              range_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_WAIT,
    ST_CAPTURE
  } state_t;

  state_t             state, state_next;
  logic signed [8:0]  deg_reg;
  logic        [7:0]  count;
  logic               attempt, out_of_range, accept;
  logic signed [11:0] d_ext, d_fold, prod, quot;
  logic signed [7:0]  angle_next;

  assign xin = XIN_INIT;
  assign yin = '0;

  assign out_of_range = (deg_in > 9'sd180) || (deg_in < -9'sd180);
  assign attempt      = deg_valid && deg_ready;
  assign accept       = attempt && !out_of_range;

  // sine_out/sine_valid are registered at the end of CAPTURE, so the FSM is
  // already back in IDLE while sine_valid is high; holding deg_ready low for
  // that cycle makes it rise only after the sine_valid pulse.
  always_comb begin
    deg_ready = (state == ST_IDLE) && !reset && !sine_valid;
  end

  // Fold into [-90,90] (sine sign preserved), then round(d*10/9) half away
  // from zero. 9 is odd so an exact half never occurs; +/-4 before the
  // truncating divide gives nearest rounding on either sign.
  always_comb begin
    d_ext = {{3{deg_reg[8]}}, deg_reg};
    if (d_ext > 12'sd90) begin
      d_fold = 12'sd180 - d_ext;
    end else if (d_ext < -12'sd90) begin
      d_fold = -12'sd180 - d_ext;
    end else begin
      d_fold = d_ext;
    end
    prod = d_fold * 12'sd10;
    if (prod < 12'sd0) begin
      quot = (prod - 12'sd4) / 12'sd9;
    end else begin
      quot = (prod + 12'sd4) / 12'sd9;
    end
    angle_next = quot[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (accept) state_next = ST_CONVERT;
      ST_CONVERT: state_next = ST_WAIT;
      ST_WAIT:    if (count == '0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deg_reg    <= '0;
      angle      <= '0;
      sine_out   <= '0;
      sine_valid <= 1'b0;
      range_err  <= 1'b0;
      count      <= '0;
    end else begin
      sine_valid <= (state == ST_CAPTURE);
      range_err  <= attempt && out_of_range;
      if (accept) begin
        deg_reg <= deg_in;
      end
      if (state == ST_CONVERT) begin
        angle <= angle_next;
        count <= 8'(LATENCY - 1);
      end else if ((state == ST_WAIT) && (count != '0)) begin
        count <= count - 8'd1;
      end
      if (state == ST_CAPTURE) begin
        sine_out <= sine_in;
      end
    end
  end

endmodule

// File: tb/tb_cordic_angle_feeder.sv
// Testbench for cordic_angle_feeder (LATENCY = 8).
module tb_cordic_angle_feeder;

  logic              clk = 1'b0;
  logic              reset;
  logic signed [8:0] deg_in;
  logic              deg_valid;
  logic              deg_ready;
  logic signed [7:0] xin, yin, angle;
  logic signed [7:0] sine_in;
  logic signed [7:0] sine_out;
  logic              sine_valid;
  logic              range_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int deg;
    int exp_angle;
    int cap;
  } vec_t;

  vec_t vecs[14];

  cordic_angle_feeder #(
    .LATENCY (8),
    .XIN_INIT(8'sd39)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .deg_in    (deg_in),
    .deg_valid (deg_valid),
    .deg_ready (deg_ready),
    .xin       (xin),
    .yin       (yin),
    .angle     (angle),
    .sine_in   (sine_in),
    .sine_out  (sine_out),
    .sine_valid(sine_valid),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: fold, then real-valued round half away from zero.
  function automatic int ref_angle(input int d);
    int  f;
    real r;
    if (d > 90) f = 180 - d;
    else if (d < -90) f = -180 - d;
    else f = d;
    r = real'(f) * 10.0 / 9.0;
    if (r >= 0.0) return int'($floor(r + 0.5));
    else return -int'($floor(-r + 0.5));
  endfunction

  // One full request: checks angle one cycle after accept, sine_valid exactly
  // 10 cycles after accept, sine_out equal to sine_in of the CAPTURE cycle.
  task automatic do_req(input int deg, input int exp_angle, input int cap, input string tag);
    int n;
    deg_in    = 9'(deg);
    deg_valid = 1'b1;
    chk({tag, " ready"}, int'(deg_ready), 1);
    step();                       // accept edge T
    deg_valid = 1'b0;
    deg_in    = 9'(-deg);         // ignored outside IDLE
    step();                       // T+1
    chk({tag, " angle"}, int'(angle), exp_angle);
    n = 1;
    while (!sine_valid && n < 40) begin
      sine_in = (n == 9) ? 8'(cap) : 8'sh5A;
      step();
      n++;
    end
    chk({tag, " latency"}, n, 10);
    chk({tag, " sine_out"}, int'(sine_out), cap);
    chk({tag, " ready_low_at_valid"}, int'(deg_ready), 0);
    sine_in = 8'sh5A;
    step();
    chk({tag, " valid_pulse"}, int'(sine_valid), 0);
    chk({tag, " ready_back"}, int'(deg_ready), 1);
    chk({tag, " angle_held"}, int'(angle), exp_angle);
  endtask

  task automatic do_bad(input int deg, input string tag);
    int prev;
    int seen;
    prev      = int'(angle);
    deg_in    = 9'(deg);
    deg_valid = 1'b1;
    step();
    deg_valid = 1'b0;
    chk({tag, " range_err"}, int'(range_err), 1);
    chk({tag, " ready"}, int'(deg_ready), 1);
    chk({tag, " angle"}, int'(angle), prev);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (sine_valid || range_err) seen++;
    end
    chk({tag, " no_extra_pulses"}, seen, 0);
  endtask

  initial begin
    int n;

    vecs[0]  = '{60,   67,  17};
    vecs[1]  = '{150,  33, -40};
    vecs[2]  = '{-120, -67,  99};
    vecs[3]  = '{90,  100, -128};
    vecs[4]  = '{-80, -89, 127};
    vecs[5]  = '{180,   0,   1};
    vecs[6]  = '{-180,  0,  -1};
    vecs[7]  = '{-90, -100, 64};
    vecs[8]  = '{0,     0,  33};
    vecs[9]  = '{1,     1, -77};
    vecs[10] = '{5,     6,  12};
    vecs[11] = '{-5,   -6, -12};
    vecs[12] = '{45,   50,  80};
    vecs[13] = '{91,   99, -99};

    // Reset state, with a request presented during reset.
    reset     = 1'b1;
    deg_valid = 1'b1;
    deg_in    = 9'sd10;
    sine_in   = 8'sh5A;
    step();
    step();
    chk("rst ready", int'(deg_ready), 0);
    chk("rst angle", int'(angle), 0);
    chk("rst sine_out", int'(sine_out), 0);
    chk("rst sine_valid", int'(sine_valid), 0);
    chk("rst range_err", int'(range_err), 0);
    chk("xin", int'(xin), 39);
    chk("yin", int'(yin), 0);
    reset     = 1'b0;
    deg_valid = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      do_req(vecs[i].deg, vecs[i].exp_angle, vecs[i].cap, $sformatf("vec%0d", i));
    end

    do_bad(181, "bad181");
    do_bad(-181, "badm181");
    do_bad(255, "bad255");

    // Back-to-back with deg_valid held high.
    deg_in    = 9'sd10;
    deg_valid = 1'b1;
    step();                         // T: 10 accepted
    deg_in = 9'sd20;
    step();
    chk("b2b angle1", int'(angle), 11);
    n = 1;
    while (!sine_valid && n < 40) begin
      step();
      n++;
    end
    chk("b2b latency1", n, 10);
    chk("b2b ready_at_valid", int'(deg_ready), 0);
    chk("b2b angle1_held", int'(angle), 11);
    step();                         // T+11
    chk("b2b ready_back", int'(deg_ready), 1);
    step();                         // 20 accepted on this edge
    chk("b2b ready_after_accept", int'(deg_ready), 0);
    deg_valid = 1'b0;
    chk("b2b angle_before_convert", int'(angle), 11);
    step();
    chk("b2b angle2", int'(angle), 22);
    n = 0;
    while (!sine_valid && n < 40) begin
      step();
      n++;
    end
    chk("b2b drain_latency", n, 9);
    step();

    // Reset in the middle of WAIT.
    deg_in    = 9'sd30;
    deg_valid = 1'b1;
    step();
    deg_valid = 1'b0;
    step();
    chk("mid angle", int'(angle), 33);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid rst angle", int'(angle), 0);
    chk("mid rst sine_out", int'(sine_out), 0);
    chk("mid rst sine_valid", int'(sine_valid), 0);
    chk("mid rst range_err", int'(range_err), 0);
    chk("mid rst ready", int'(deg_ready), 0);
    reset = 1'b0;
    #1;
    chk("mid ready_after_rst", int'(deg_ready), 1);
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (sine_valid) n++;
    end
    chk("mid no_sine_valid", n, 0);
    do_req(45, 50, -50, "post_rst");

    // Full sweep against the reference model.
    for (int d = -180; d <= 180; d++) begin
      do_req(d, ref_angle(d), (d * 3) % 100, $sformatf("sweep%0d", d));
      chk($sformatf("sweep%0d mag", d), int'(angle >= -8'sd100 && angle <= 8'sd100), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
